// File: rtl/bsync_generator_mc.sv
// rtl/bsync_generator_mc.sv - multi-channel BSYNC regenerator with period/high measurement and edge checking
// Optional feature macro: BSYNC_GEN_AUTO_RECAL_EN (GEN misalignment re-arms instead of locking in ERROR).
module bsync_generator_mc #(
   parameter int NUM_CH      = 4,
   parameter int CNT_WIDTH   = 16,
   parameter int TOL         = 1,
   parameter int SYNC_STAGES = 3
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          enable,
   input  logic                          bsync_in,
   input  logic [NUM_CH-1:0]             ch_enable,
   input  logic [NUM_CH*CNT_WIDTH-1:0]   ch_phase,
   input  logic                          misalign_check_en,
   input  logic                          clear_error,
   output logic                          bsync_ready,
   output logic [CNT_WIDTH-1:0]          bsync_period,
   output logic [CNT_WIDTH-1:0]          bsync_high,
   output logic [CNT_WIDTH-1:0]          bsync_phase_err,
   output logic [2:0]                    bsync_state,
   output logic                          bsync_error,
   output logic                          bsync_event,
   output logic [NUM_CH-1:0]             bsync_out
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_MEAS  = 3'd2,
      ST_GEN   = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   localparam logic [CNT_WIDTH-1:0] TOL_C = CNT_WIDTH'(TOL);
   localparam logic [CNT_WIDTH-1:0] ONES  = '1;
   localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);

   logic                         rst_meta_q;
   logic                         rst_sync_n_q;
   logic [SYNC_STAGES-1:0]       sync_q;
   logic                         lvl_q;
   logic                         event_q;

   state_t                       state_q, state_d;
   logic [CNT_WIDTH-1:0]         mcnt_q, mcnt_d;
   logic [CNT_WIDTH-1:0]         hcnt_q, hcnt_d;
   logic [CNT_WIDTH-1:0]         per_q, per_d;
   logic [CNT_WIDTH-1:0]         high_q, high_d;
   logic [CNT_WIDTH-1:0]         perr_q, perr_d;
   logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
   logic                         err_q, err_d;
   logic [NUM_CH*CNT_WIDTH-1:0]  ph_q, ph_d;
   logic [NUM_CH-1:0]            out_q, out_d;

   logic [CNT_WIDTH-1:0]         dev;
   logic [CNT_WIDTH-1:0]         per_meas;
   logic                         wrap;
   logic                         misalign;
   logic                         gen_hold;

   // Reset asserts asynchronously, releases two clocks after rstn rises.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rst_meta_q   <= 1'b0;
         rst_sync_n_q <= 1'b0;
      end else begin
         rst_meta_q   <= 1'b1;
         rst_sync_n_q <= rst_meta_q;
      end
   end

   always_ff @(posedge clk or negedge rst_sync_n_q) begin
      if (!rst_sync_n_q) begin
         sync_q  <= '0;
         lvl_q   <= 1'b0;
         event_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], bsync_in};
         lvl_q   <= sync_q[SYNC_STAGES-1];
         event_q <= sync_q[SYNC_STAGES-1] & ~lvl_q;
      end
   end

   always_comb begin
      dev      = (cnt_q <= (per_q >> 1)) ? cnt_q : (per_q - cnt_q);
      per_meas = mcnt_q + ONE;
      wrap     = (cnt_q == per_q - ONE);
      misalign = event_q & misalign_check_en & (dev > TOL_C);
   end

   always_comb begin
      state_d = state_q;
      mcnt_d  = mcnt_q;
      hcnt_d  = hcnt_q;
      per_d   = per_q;
      high_d  = high_q;
      perr_d  = perr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ph_d    = ph_q;
`ifdef BSYNC_GEN_AUTO_RECAL_EN
      if (clear_error) begin
         err_d = 1'b0;
      end
`endif
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_ARM;
            end
         end
         ST_ARM: begin
            // The edge cycle itself is high and opens the first measured period.
            if (event_q) begin
               state_d = ST_MEAS;
               mcnt_d  = '0;
               hcnt_d  = ONE;
            end
         end
         ST_MEAS: begin
            mcnt_d = mcnt_q + ONE;
            hcnt_d = hcnt_q + CNT_WIDTH'(lvl_q);
            if (mcnt_q == ONES) begin
               state_d = ST_ERROR;
               err_d   = 1'b1;
            end else if (event_q) begin
               per_d  = per_meas;
               high_d = hcnt_q;
               if (per_meas < CNT_WIDTH'(2)) begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
               end else begin
                  // The entering edge is phase 0, so the first GEN cycle is phase 1.
                  state_d = ST_GEN;
                  cnt_d   = ONE;
                  ph_d    = ch_phase;
               end
            end
         end
         ST_GEN: begin
            cnt_d = wrap ? '0 : cnt_q + ONE;
            if (wrap) begin
               ph_d = ch_phase;
            end
            if (event_q) begin
               perr_d = cnt_q;
            end
            if (misalign) begin
               err_d = 1'b1;
`ifdef BSYNC_GEN_AUTO_RECAL_EN
               state_d = ST_ARM;
`else
               state_d = ST_ERROR;
`endif
            end
         end
         ST_ERROR: begin
            if (clear_error) begin
               state_d = ST_IDLE;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Disable wins over every edge, clear and measurement update.
      if (!enable) begin
         state_d = ST_IDLE;
         per_d   = per_q;
         high_d  = high_q;
         perr_d  = perr_q;
         err_d   = err_q;
      end
   end

   assign gen_hold = (state_q == ST_GEN) && (state_d == ST_GEN);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [CNT_WIDTH-1:0] ph;
      logic [CNT_WIDTH:0]   rel_raw;
      logic [CNT_WIDTH:0]   rel;
      assign ph      = ph_q[g*CNT_WIDTH +: CNT_WIDTH];
      assign rel_raw = {1'b0, cnt_q} + {1'b0, per_q} - {1'b0, ph};
      assign rel     = (rel_raw >= {1'b0, per_q}) ? (rel_raw - {1'b0, per_q}) : rel_raw;
      assign out_d[g] = ch_enable[g] & gen_hold & (ph < per_q) & (rel < {1'b0, high_q});
   end

   always_ff @(posedge clk or negedge rst_sync_n_q) begin
      if (!rst_sync_n_q) begin
         state_q <= ST_IDLE;
         mcnt_q  <= '0;
         hcnt_q  <= '0;
         per_q   <= '0;
         high_q  <= '0;
         perr_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         ph_q    <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         mcnt_q  <= mcnt_d;
         hcnt_q  <= hcnt_d;
         per_q   <= per_d;
         high_q  <= high_d;
         perr_q  <= perr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ph_q    <= ph_d;
         out_q   <= out_d;
      end
   end

   assign bsync_ready     = (state_q == ST_GEN);
   assign bsync_period    = per_q;
   assign bsync_high      = high_q;
   assign bsync_phase_err = perr_q;
   assign bsync_state     = state_q;
   assign bsync_error     = err_q;
   assign bsync_event     = event_q;
   assign bsync_out       = out_q;

endmodule
